// File: rtl/cordic_ln_pkg.sv
// Shared definitions for the hyperbolic CORDIC ln/exp engine.
// Contents: FSM state encoding, micro-rotation repeat indices, range limits
// and the gain-compensation constant (kept as reals and scaled to the
// instance's FRAC by to_fx), the step-count function, and the constant
// functions that build the atanh(2^-i) table at elaboration time.
package cordic_ln_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROTATE = 2'd2,
    ST_FINAL  = 2'd3
  } state_t;

  // Shift indices executed twice so the hyperbolic iteration converges.
  localparam int REP_IDX_A = 4;
  localparam int REP_IDX_B = 13;

  // Operand range limits and the hyperbolic gain, scaled by to_fx.
  localparam real LN_T_MIN_R  = 0.125;
  localparam real LN_T_MAX_R  = 9.0;
  localparam real EXP_T_MAX_R = 1.0;
  // Product of sqrt(1 - 2^-2i) over the 4/13 repeat schedule.
  localparam real KH_R        = 0.8281593609602;
  // Starting x in exp mode is the reciprocal of that gain, so x+y lands on e^T.
  localparam real KH_INV_R    = 1.0 / KH_R;

  function automatic int steps(input int iter);
    return iter + ((iter >= REP_IDX_A) ? 1 : 0) + ((iter >= REP_IDX_B) ? 1 : 0);
  endfunction

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    for (int k = 0; k < e; k++) r = r * 2.0;
    return r;
  endfunction

  // Real to fixed point with FRAC fractional bits (cast rounds to nearest).
  function automatic longint to_fx(input real v, input int frac);
    return longint'(v * pow2(frac));
  endfunction

  // atanh(2^-i) from its odd power series, rounded to FRAC bits.
  function automatic longint atanh_fx(input int i, input int frac);
    real x;
    real x2;
    real term;
    real acc;
    x    = 1.0 / pow2(i);
    x2   = x * x;
    term = x;
    acc  = 0.0;
    for (int n = 1; n < 80; n += 2) begin
      acc  = acc + term / $itor(n);
      term = term * x2;
    end
    return to_fx(acc, frac);
  endfunction

endpackage

// File: rtl/cordic_atanh_rom.sv
// Combinational table of atanh(2^-i), i = 1..ITER, rounded to FRAC bits and
// sign-extended to the XW-bit datapath width.
// Ports:
//   idx        in  IW  current shift index (1..ITER); other values give 0
//   atanh_val  out XW  atanh(2^-idx) in Q(XW-FRAC).FRAC
module cordic_atanh_rom
  import cordic_ln_pkg::*;
#(
  parameter int XW   = 34,
  parameter int FRAC = 28,
  parameter int ITER = 16,
  parameter int IW   = 5
) (
  input  logic [IW-1:0]        idx,
  output logic signed [XW-1:0] atanh_val
);

  logic signed [XW-1:0] rom [ITER];

  generate
    for (genvar gi = 0; gi < ITER; gi++) begin : g_rom
      localparam longint ENTRY = atanh_fx(gi + 1, FRAC);
      assign rom[gi] = XW'(ENTRY);
    end
  endgenerate

  always_comb begin
    atanh_val = '0;
    for (int k = 0; k < ITER; k++) begin
      if (int'(idx) == k + 1) atanh_val = rom[k];
    end
  end

endmodule

// File: rtl/cordic_ln_core.sv
// Iterative hyperbolic CORDIC: ln(T) in vectoring mode, exp(T) in rotation
// mode, one micro-rotation per clock, constant latency STEPS+2 cycles.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   start request, sampled only while idle
//   mode    in   0 = ln, 1 = exp; captured with start
//   t       in   W-bit signed operand, Q(W-FRAC).FRAC; captured with start
//   busy    out  high from the cycle after acceptance until done
//   done    out  one-cycle pulse, result valid
//   o_f     out  overflow flag, valid with done
//   u_f     out  underflow / invalid-operand flag, valid with done
//   result  out  W-bit result, held until the next operation finishes
// Build option: define CORDIC_SAT_EN to saturate result on flagged operations.
module cordic_ln_core
  import cordic_ln_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = W - 4,
  parameter int ITER = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] t,
  output logic         busy,
  output logic         done,
  output logic         o_f,
  output logic         u_f,
  output logic [W-1:0] result
);

  // State carries two guard integer bits so T+1 near the top of the operand
  // range and the intermediate growth of x/y do not wrap.
  localparam int XW    = W + 2;
  localparam int STEPS = steps(ITER);
  localparam int CW    = $clog2(STEPS + 1);
  localparam int IW    = $clog2(ITER + 1);

  localparam longint LN_T_MIN  = to_fx(LN_T_MIN_R, FRAC);
  localparam longint LN_T_MAX  = to_fx(LN_T_MAX_R, FRAC);
  localparam longint EXP_T_MAX = to_fx(EXP_T_MAX_R, FRAC);
  localparam logic signed [XW-1:0] KH_INV = XW'(to_fx(KH_INV_R, FRAC));
  localparam logic signed [XW-1:0] ONE    = XW'(longint'(1) << FRAC);

  state_t               state_reg;
  logic                 mode_reg;
  logic [W-1:0]         t_reg;
  logic signed [XW-1:0] x_reg, y_reg, z_reg;
  logic [CW-1:0]        cnt_reg;

  logic [IW-1:0]        shift_idx;
  logic signed [XW-1:0] atanh_val;
  logic signed [XW-1:0] t_ext;
  longint               t_l;
  logic                 d_pos;
  logic signed [XW-1:0] x_sh, y_sh;
  logic signed [XW-1:0] x_next, y_next, z_next;
  logic signed [XW-1:0] fin_sum;
  logic                 fin_ovf;
  logic [W-1:0]         res_next;

  // Step count -> shift index. One repeat of 4 is inserted from step 4 on,
  // the repeat of 13 from step 14 on (13 plus the already-inserted step).
  always_comb begin
    shift_idx = IW'(int'(cnt_reg) + 1
                    - ((int'(cnt_reg) >= REP_IDX_A) ? 1 : 0)
                    - ((int'(cnt_reg) >= REP_IDX_B + 1) ? 1 : 0));
  end

  cordic_atanh_rom #(
    .XW  (XW),
    .FRAC(FRAC),
    .ITER(ITER),
    .IW  (IW)
  ) u_rom (
    .idx      (shift_idx),
    .atanh_val(atanh_val)
  );

  assign t_ext = {{2{t_reg[W-1]}}, t_reg};
  assign t_l   = longint'($signed(t_reg));

  // Vectoring drives y to zero, rotation drives z to zero.
  assign d_pos  = mode_reg ? ~z_reg[XW-1] : y_reg[XW-1];
  assign x_sh   = x_reg >>> shift_idx;
  assign y_sh   = y_reg >>> shift_idx;
  assign x_next = d_pos ? (x_reg + y_sh) : (x_reg - y_sh);
  assign y_next = d_pos ? (y_reg + x_sh) : (y_reg - x_sh);
  assign z_next = d_pos ? (z_reg - atanh_val) : (z_reg + atanh_val);

  assign fin_sum = mode_reg ? (x_reg + y_reg) : (z_reg <<< 1);
  // The value fits W bits only if the top three bits agree.
  assign fin_ovf = ~((&fin_sum[XW-1:W-1]) | ~(|fin_sum[XW-1:W-1]));

  always_comb begin
    res_next = fin_sum[W-1:0];
`ifdef CORDIC_SAT_EN
    if (u_f)
      res_next = mode_reg ? '0 : {1'b1, {(W-1){1'b0}}};
    else if (o_f || fin_ovf)
      res_next = {1'b0, {(W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      mode_reg  <= 1'b0;
      t_reg     <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      o_f       <= 1'b0;
      u_f       <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mode_reg  <= mode;
            t_reg     <= t;
            o_f       <= 1'b0;
            u_f       <= 1'b0;
            busy      <= 1'b1;
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_reg <= '0;
          if (!mode_reg) begin
            x_reg <= t_ext + ONE;
            y_reg <= t_ext - ONE;
            z_reg <= '0;
            u_f   <= (t_l <= 0) || (t_l < LN_T_MIN);
            o_f   <= (t_l > LN_T_MAX);
          end else begin
            x_reg <= KH_INV;
            y_reg <= '0;
            z_reg <= t_ext;
            o_f   <= (t_l > EXP_T_MAX);
            u_f   <= (t_l < -EXP_T_MAX);
          end
          state_reg <= ST_ROTATE;
        end
        ST_ROTATE: begin
          x_reg <= x_next;
          y_reg <= y_next;
          z_reg <= z_next;
          if (cnt_reg == CW'(STEPS - 1)) begin
            cnt_reg   <= '0;
            state_reg <= ST_FINAL;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_FINAL: begin
          result    <= res_next;
          o_f       <= o_f | fin_ovf;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_ln_core.sv
`timescale 1ns/1ps
module tb_cordic_ln_core;

  localparam int     W     = 32;
  localparam int     FRAC  = 28;
  localparam int     ITER  = 16;
  localparam int     LAT   = 20;
  localparam real    SCALE = 268435456.0;
  localparam longint TOL   = longint'(1) << (FRAC - (ITER - 2));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] t = '0;
  logic         busy, done, o_f, u_f;
  logic [W-1:0] result;

  cordic_ln_core #(.W(W), .FRAC(FRAC), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .t(t),
    .busy(busy), .done(done), .o_f(o_f), .u_f(u_f), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit           mode;
    logic [W-1:0] t;
    bit           exp_of;
    bit           exp_uf;
    bit           chk_val;
    longint       exp_val;
    bit           exact;
    logic [W-1:0] exact_bits;
    int           due;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: real-valued ln/exp and the operand range rules.
  function automatic item_t model(input bit m, input logic [W-1:0] tv);
    item_t it;
    real tr, ideal;
    tr = $itor($signed(tv)) / SCALE;
    it.mode = m; it.t = tv; it.exp_of = 0; it.exp_uf = 0;
    it.exact = 0; it.exact_bits = '0; it.due = 0;
    ideal = 0.0;
    if (!m) begin
      if (tr < 0.125)     it.exp_uf = 1;
      else if (tr > 9.0)  it.exp_of = 1;
      else                ideal = $ln(tr);
    end else begin
      if (tr > 1.0)       it.exp_of = 1;
      else if (tr < -1.0) it.exp_uf = 1;
      else                ideal = $exp(tr);
    end
    it.chk_val = !(it.exp_of || it.exp_uf);
    it.exp_val = longint'(ideal * SCALE);
`ifdef CORDIC_SAT_EN
    if (it.exp_uf) begin
      it.exact = 1; it.exact_bits = m ? 32'h0000_0000 : 32'h8000_0000;
    end else if (it.exp_of) begin
      it.exact = 1; it.exact_bits = 32'h7FFF_FFFF;
    end
`endif
    return it;
  endfunction

  // Scoreboard monitor: pops one expectation per done pulse.
  always @(negedge clk) begin : monitor
    item_t  it;
    longint diff;
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 result=%h expected no done", result);
        end else begin
          it = sb.pop_front();
          $display("txn mode=%0d t=%h result=%h o_f=%0d u_f=%0d cycle=%0d",
                   it.mode, it.t, result, o_f, u_f, cyc);
          chk("latency_cycle", longint'(cyc), longint'(it.due));
          chk("o_f", longint'(o_f), longint'(it.exp_of));
          chk("u_f", longint'(u_f), longint'(it.exp_uf));
          chk("busy_at_done", longint'(busy), 0);
          if (it.chk_val) begin
            diff = longint'($signed(result)) - it.exp_val;
            if (diff < 0) diff = -diff;
            checks++;
            if (diff > TOL) begin
              errors++;
              $display("FAIL value mode=%0d t=%h: got %h expected %h (tol %0d)",
                       it.mode, it.t, result, it.exp_val[31:0], TOL);
            end
          end
          if (it.exact) chk("sat_result", longint'(result), longint'(it.exact_bits));
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        it = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_done t=%h: got no done by cycle %0d expected at %0d",
                 it.t, cyc, it.due);
      end
    end
  end

  // Called just after a rising edge; the start is accepted on the next edge.
  task automatic issue(input bit m, input logic [W-1:0] tv);
    item_t it;
    it = model(m, tv);
    it.due = cyc + 1 + LAT;
    start = 1'b1; mode = m; t = tv;
    sb.push_back(it);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", longint'(busy), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    chk("scoreboard_drained", longint'(sb.size()), 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("done_seen", longint'(done), 1);
  endtask

  localparam int NDIR = 16;
  bit           dir_mode [NDIR] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                                    1, 1, 1, 1, 1, 1, 1};
  logic [W-1:0] dir_t    [NDIR] = '{32'h1000_0000, 32'h2B7E_1516, 32'h2000_0000,
                                    32'h0000_0000, 32'hA000_0000, 32'h9800_0000,
                                    32'h7000_0000, 32'h0200_0000, 32'h01FF_FFFF,
                                    32'h0000_0000, 32'h1000_0000, 32'h1800_0000,
                                    32'hF000_0000, 32'hEFFF_FFFF, 32'h1000_0001,
                                    32'hE800_0000};

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W-1:0] tv;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_o_f", longint'(o_f), 0);
    chk("reset_u_f", longint'(u_f), 0);
    chk("reset_result", longint'(result), 0);
    @(posedge clk); #1;

    for (int i = 0; i < NDIR; i++) begin
      issue(dir_mode[i], dir_t[i]);
      wait_idle();
    end

    for (int i = 0; i < 12; i++) begin
      issue(1'b0, 32'($urandom_range(32'h7F00_0000, 32'h0200_0000)));
      wait_idle();
      tv = 32'($urandom_range(32'h2000_0000, 0)) - 32'h1000_0000;
      issue(1'b1, tv);
      wait_idle();
    end
    for (int i = 0; i < 8; i++) begin
      issue(1'($urandom_range(1, 0)), 32'($urandom));
      wait_idle();
    end

    // Back-to-back chain: each start is raised in the previous done cycle.
    issue(1'b0, 32'h3000_0000);
    for (int i = 0; i < 3; i++) begin
      wait_done();
      tv = 32'($urandom_range(32'h2000_0000, 0)) - 32'h1000_0000;
      issue(1'b1, tv);
    end
    wait_idle();

    // A start while busy must be ignored.
    issue(1'b0, 32'h2000_0000);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; mode = 1'b1; t = 32'h0800_0000;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_ignored_start", longint'(busy), 1);
    wait_idle();

    // Asynchronous reset during a flagged operation.
    issue(1'b1, 32'h1800_0000);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_busy", longint'(busy), 0);
    chk("midreset_done", longint'(done), 0);
    chk("midreset_o_f", longint'(o_f), 0);
    chk("midreset_u_f", longint'(u_f), 0);
    chk("midreset_result", longint'(result), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'h2B7E_1516);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
